uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side byte buffer between the uart_rx deserialiser and the GPIO/MMIO load path.
//  Captures each byte uart_rx delivers into a DEPTH-entry FIFO, so software polling no
//  longer loses bytes between reads.
//  Presents the head byte first-word-fall-through, with empty/full/count/overflow status.
//  The MMIO decoder reads these outputs and pulses pop_i.
// PARAMETERS
//  DEPTH   16  number of byte entries; must be a power of 2, >= 2
//  ADDR_W  4   log2(DEPTH); pointer width
// PORTS
//  clk_i             in   1         system clock
//  rst_i             in   1         asynchronous, active-high reset
//  byte_i            in   8         received byte from uart_rx (valid while byte_ready_i=1)
//  byte_ready_i      in   1         uart_rx byte-ready flag (level or pulse)
//  pop_i             in   1         1-cycle pulse: consume head entry
//  clear_overflow_i  in   1         1-cycle pulse: clear sticky overflow flag
//  data_o            out  8         head byte (FWFT); 8'h00 when empty
//  empty_o           out  1         FIFO holds 0 entries
//  full_o            out  1         FIFO holds DEPTH entries
//  count_o           out  ADDR_W+1  current occupancy, 0..DEPTH
//  overflow_o        out  1         sticky: a byte was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset (async, rst_i=1): wr_ptr=rd_ptr=0, count_o=0, empty_o=1, full_o=0, overflow_o=0,
//    data_o=0, ready_q=0. Storage array is not reset. Reset mid-stream discards all entries.
//  - Push detect:
//    - ready_q <= byte_ready_i every cycle; push_req = byte_ready_i & ~ready_q.
//    - A level held high for N cycles therefore pushes exactly once.
//  - Push: on push_req, mem[wr_ptr] <= byte_i at that clock edge; wr_ptr increments mod DEPTH.
//  - Latency: byte_ready_i rising at edge k -> empty_o=0, data_o=byte after edge k (1 clk).
//  - Pop: on pop_i with count_o>0, rd_ptr increments mod DEPTH; new head visible next cycle.
//  - Pop while empty: ignored. No pointer change, no error flag.
//  - Simultaneous push_req & pop_i:
//    - count_o 1..DEPTH-1: both happen, count unchanged.
//    - empty: push only.
//    - full: both happen; the write goes to the slot freed by the pop; no overflow.
//  - Overflow: push_req while full and no pop_i -> byte dropped, pointers and storage
//    unchanged, overflow_o <= 1.
//  - overflow_o stays set until clear_overflow_i. If a clear and a new overflow occur in the
//    same cycle, set wins.
//  - Count arithmetic: count_o is ADDR_W+1 bits, updated as +1 / -1 / 0.
//    - Flags decode from the count: empty_o = (count_o==0), full_o = (count_o==DEPTH).
//    - Pointers wrap naturally at ADDR_W bits.
//  - data_o: combinational mem[rd_ptr], gated to 8'h00 when empty_o.
//  - All flags and count_o are registered state or direct decodes of it; no comb path from
//    pop_i to any output.
// STRUCTURE
//  - constant_defs.v gains `UART_RX_FIFO_DEPTH (16) and the MMIO offsets for the FIFO
//    data/pop, status (empty/full/count), and overflow-clear registers used by gpio.
//  - One sub-module: fifo_regfile
//    - Params: DEPTH x 8 register array.
//    - Ports: one sync write port (we, waddr, wdata) and one async read port (raddr -> rdata).
//  - Pointer, count, edge-detect and flag logic stay in uart_rx_fifo.
// TESTING
//  1. Reset, no input -> empty_o=1, full_o=0, count_o=0, data_o=8'h00, overflow_o=0.
//  2. Push 8'hA5 (byte_ready_i high 3 cycles) -> exactly one entry; count_o=1,
//     data_o=8'hA5 one clk after the rise.
//  3. Push 8'h01..8'h10 (16 bytes) -> full_o=1, count_o=16. Push 8'h11 -> overflow_o=1,
//     count_o stays 16. Pop 16x -> 8'h01..8'h10 in order, then empty_o=1.
//  4. Full FIFO, push 8'h77 and pop_i same cycle -> overflow_o stays 0, count_o=16,
//     8'h77 emerges last.
//  5. Empty FIFO, pop_i pulse -> no change. Push 8'h3C with pop_i same cycle -> count_o=1,
//     data_o=8'h3C.
//  6. Five entries plus overflow_o=1, assert rst_i between clock edges -> all outputs at reset
//     values immediately. clear_overflow_i together with an overflowing push -> overflow_o
//     remains 1.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared sizing constants and types for the UART receive FIFO.
package uart_rx_fifo_pkg;

  localparam int unsigned FIFO_DEPTH  = 16;
  localparam int unsigned FIFO_ADDR_W = 4;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte-in / status-out bundle between uart_rx, the FIFO and the MMIO decoder.
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = FIFO_ADDR_W
);

  byte_t           byte_i;
  logic            byte_ready_i;
  logic            pop_i;
  logic            clear_overflow_i;
  byte_t           data_o;
  logic            empty_o;
  logic            full_o;
  logic [ADDR_W:0] count_o;
  logic            overflow_o;

  modport master (
    output byte_i, byte_ready_i, pop_i, clear_overflow_i,
    input  data_o, empty_o, full_o, count_o, overflow_o
  );

  modport slave (
    input  byte_i, byte_ready_i, pop_i, clear_overflow_i,
    output data_o, empty_o, full_o, count_o, overflow_o
  );

endinterface

// File: rtl/fifo_regfile.sv
// DEPTH x 8 storage: one synchronous write port, one asynchronous read port.
module fifo_regfile
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  byte_t             wdata,
  input  logic [ADDR_W-1:0] raddr,
  output byte_t             rdata
);

  byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO fed by uart_rx's byte-ready flag, with sticky overflow.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
  input logic            clk_i,
  input logic            rst_i,
  uart_rx_fifo_if.slave  bus
);

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

  logic              ready_q;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q;
  logic              push_req, is_empty, is_full;
  logic              do_push, do_pop, overflow_set;
  byte_t             rdata;

  assign push_req = bus.byte_ready_i & ~ready_q;
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FullCount);
  assign do_pop   = bus.pop_i & ~is_empty;
  // When full, a same-cycle pop frees the slot the write lands in (wr_ptr == rd_ptr).
  assign do_push      = push_req & (~is_full | bus.pop_i);
  assign overflow_set = push_req & is_full & ~bus.pop_i;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ready_q <= bus.byte_ready_i;
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (overflow_set)              overflow_q <= 1'b1;
      else if (bus.clear_overflow_i) overflow_q <= 1'b0;
    end
  end

  fifo_regfile #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk   (clk_i),
    .we    (do_push),
    .waddr (wr_ptr_q),
    .wdata (bus.byte_i),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign bus.data_o     = is_empty ? 8'h00 : rdata;
  assign bus.empty_o    = is_empty;
  assign bus.full_o     = is_full;
  assign bus.count_o    = count_q;
  assign bus.overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue model.
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_if bus ();

  uart_rx_fifo dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Reference model: a byte queue, a sticky flag and the last driven ready level.
  byte_t mq[$];
  bit    m_ovf  = 1'b0;
  logic  m_prev = 1'b0;

  // Inputs are applied at a falling edge; returns at the next falling edge.
  task automatic step(input logic br, input byte_t b, input logic p, input logic c);
    bit push, full;
    bus.byte_ready_i     = br;
    bus.byte_i           = b;
    bus.pop_i            = p;
    bus.clear_overflow_i = c;
    @(posedge clk);
    push = br && !m_prev;
    full = (mq.size() == FIFO_DEPTH);
    if (push && full && !p) m_ovf = 1'b1;
    else if (c)             m_ovf = 1'b0;
    if (p && mq.size() > 0) void'(mq.pop_front());
    if (push && (!full || p)) mq.push_back(b);
    m_prev = br;
    @(negedge clk);
  endtask

  task automatic push_byte(input byte_t b);
    step(1'b1, b, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty_o); end
    checks++; if (bus.full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full_o); end
    checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count_o); end
    checks++; if (bus.data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.data_o); end
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.overflow_o); end
  endtask

  task automatic test_level_push();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    checks++; if (bus.count_o !== 5'd1) begin errors++; $display("FAIL level_count1: got %0d want 1", bus.count_o); end
    checks++; if (bus.data_o !== 8'hA5) begin errors++; $display("FAIL level_data: got %h want a5", bus.data_o); end
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    checks++; if (bus.count_o !== 5'd1) begin errors++; $display("FAIL level_once: got %0d want 1", bus.count_o); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL level_drain: got %b want 1", bus.empty_o); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 16; i++) push_byte(byte_t'(i));
    checks++; if (bus.full_o !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", bus.full_o); end
    checks++; if (bus.count_o !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d want 16", bus.count_o); end
    push_byte(8'h11);
    checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", bus.overflow_o); end
    checks++; if (bus.count_o !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d want 16", bus.count_o); end
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (bus.data_o !== byte_t'(i)) begin
        errors++; $display("FAIL fill_order[%0d]: got %h want %h", i, bus.data_o, byte_t'(i));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL fill_empty: got %b want 1", bus.empty_o); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", bus.overflow_o); end
  endtask

  task automatic test_full_push_pop();
    byte_t saved [16];
    for (int i = 0; i < 16; i++) begin
      saved[i] = byte_t'($urandom);
      push_byte(saved[i]);
    end
    step(1'b1, 8'h77, 1'b1, 1'b0);
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b want 0", bus.overflow_o); end
    checks++; if (bus.count_o !== 5'd16) begin errors++; $display("FAIL fpp_count: got %0d want 16", bus.count_o); end
    for (int i = 1; i <= 16; i++) begin
      byte_t want;
      want = (i == 16) ? 8'h77 : saved[i];
      checks++;
      if (bus.data_o !== want) begin
        errors++; $display("FAIL fpp_order[%0d]: got %h want %h", i, bus.data_o, want);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_empty_pop();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL epop_count: got %0d want 0", bus.count_o); end
    checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL epop_empty: got %b want 1", bus.empty_o); end
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    checks++; if (bus.count_o !== 5'd1) begin errors++; $display("FAIL epush_count: got %0d want 1", bus.count_o); end
    checks++; if (bus.data_o !== 8'h3C) begin errors++; $display("FAIL epush_data: got %h want 3c", bus.data_o); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 17; i++) push_byte(byte_t'(8'h40 + i));
    for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (bus.count_o !== 5'd5) begin errors++; $display("FAIL pre_rst_count: got %0d want 5", bus.count_o); end
    checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL pre_rst_ovf: got %b want 1", bus.overflow_o); end
    #2 rst = 1'b1;
    #1;
    test_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(byte_t'($urandom));
    step(1'b1, 8'h99, 1'b0, 1'b1);
    checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL set_wins: got %b want 1", bus.overflow_o); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL clr_after: got %b want 0", bus.overflow_o); end
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      int    pop_pct;
      byte_t exp_data;
      pop_pct = (n < 1000) ? 10 : ((n < 2000) ? 50 : 30);
      step(logic'($urandom_range(1, 0)), byte_t'($urandom),
           logic'($urandom_range(99, 0) < pop_pct), logic'($urandom_range(99, 0) < 3));
      exp_data = (mq.size() > 0) ? mq[0] : 8'h00;
      checks++;
      if (bus.count_o !== 5'(mq.size()) || bus.data_o !== exp_data ||
          bus.empty_o !== (mq.size() == 0) || bus.full_o !== (mq.size() == FIFO_DEPTH) ||
          bus.overflow_o !== m_ovf) begin
        errors++;
        $display("FAIL rand[%0d]: got cnt=%0d data=%h e=%b f=%b ovf=%b want cnt=%0d data=%h ovf=%b",
                 n, bus.count_o, bus.data_o, bus.empty_o, bus.full_o, bus.overflow_o,
                 mq.size(), exp_data, m_ovf);
      end
    end
  endtask

  initial begin
    bus.byte_i           = 8'h00;
    bus.byte_ready_i     = 1'b0;
    bus.pop_i            = 1'b0;
    bus.clear_overflow_i = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    test_level_push();
    test_fill_overflow();
    test_full_push_pop();
    test_empty_pop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
